// File: rtl/mul40_pkg.sv
// Shared widths, partial-product line count and the 3:2 compressor majority
// function used by the multiplier datapath.
package mul40_pkg;

  localparam int OPW    = 40;
  localparam int PW     = 2 * OPW;
  localparam int NLINES = 40;

  function automatic logic [PW-1:0] maj3(input logic [PW-1:0] x,
                                         input logic [PW-1:0] y,
                                         input logic [PW-1:0] z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/mul40_tree_sched_if.sv
// Request/response bundle for the shared 40x40 multiplier.
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high; a producer holds valid and its payload until that edge.
interface mul40_tree_sched_if
  import mul40_pkg::*;
#(
  parameter int OPW = mul40_pkg::OPW,
  parameter int PW  = mul40_pkg::PW
);

  logic           req0_valid;
  logic           req0_ready;
  logic [OPW-1:0] req0_a;
  logic [OPW-1:0] req0_b;
  logic           req1_valid;
  logic           req1_ready;
  logic [OPW-1:0] req1_a;
  logic [OPW-1:0] req1_b;
  logic           resp_valid;
  logic           resp_ready;
  logic           resp_id;
  logic [PW-1:0]  resp_p;
  logic [15:0]    done_cnt;

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, resp_ready,
    input  req0_ready, req1_ready, resp_valid, resp_id, resp_p, done_cnt
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, resp_ready,
    output req0_ready, req1_ready, resp_valid, resp_id, resp_p, done_cnt
  );

endinterface

// File: rtl/csa_tree_40x80.sv
// Combinational carry-save reduction of the 40 shifted partial products of
// i_a*i_b into a sum/carry pair whose modular sum is the product.
module csa_tree_40x80
  import mul40_pkg::*;
(
  input  logic [OPW-1:0] i_a,
  input  logic [OPW-1:0] i_b,
  output logic [PW-1:0]  o_sum,
  output logic [PW-1:0]  o_carry
);

  logic [PW-1:0] w_sum;
  logic [PW-1:0] w_carry;
  logic [PW-1:0] w_line;
  logic [PW-1:0] w_nsum;

  always_comb begin
    w_sum   = '0;
    w_carry = '0;
    w_line  = '0;
    w_nsum  = '0;
    for (int i = 0; i < NLINES; i++) begin
      w_line  = i_b[i] ? ({{(PW-OPW){1'b0}}, i_a} << i) : '0;
      w_nsum  = w_sum ^ w_carry ^ w_line;
      // The carry out of bit PW-1 falls off: everything is mod 2^PW.
      w_carry = maj3(w_sum, w_carry, w_line) << 1;
      w_sum   = w_nsum;
    end
  end

  assign o_sum   = w_sum;
  assign o_carry = w_carry;

endmodule

// File: rtl/mul40_tree_sched.sv
// Two requesters share one CSA tree through a round-robin arbiter; a 2-stage
// pipeline (tree result, then final add) delivers products with backpressure.
module mul40_tree_sched
  import mul40_pkg::*;
#(
  parameter int OPW = mul40_pkg::OPW,
  parameter int PW  = mul40_pkg::PW
)
(
  input  logic               clk,
  input  logic               rst_n,
  mul40_tree_sched_if.slave  bus
);

  logic           r_s1_valid;
  logic           r_s1_id;
  logic [PW-1:0]  r_s1_sum;
  logic [PW-1:0]  r_s1_carry;
  logic           r_s2_valid;
  logic           r_s2_id;
  logic [PW-1:0]  r_s2_p;
  logic [15:0]    r_done;
  logic           r_last;

  logic           w_stall;
  logic           w_grant0;
  logic           w_grant1;
  logic           w_accept_ok;
  logic           w_take;
  logic           w_id;
  logic [OPW-1:0] w_a;
  logic [OPW-1:0] w_b;
  logic [PW-1:0]  w_sum;
  logic [PW-1:0]  w_carry;

  // When S2 is not stalled, S1 is either empty or moving on, so it can load.
  assign w_stall     = r_s2_valid & ~bus.resp_ready;
  assign w_accept_ok = rst_n & ~w_stall;

  // r_last holds the id of the most recent grant; a tie goes to the other one.
  assign w_grant0 = bus.req0_valid & (~bus.req1_valid | r_last);
  assign w_grant1 = bus.req1_valid & ~w_grant0;

  assign bus.req0_ready = w_accept_ok & w_grant0;
  assign bus.req1_ready = w_accept_ok & w_grant1;

  assign w_take = bus.req0_ready | bus.req1_ready;
  assign w_id   = bus.req1_ready;
  assign w_a    = w_id ? bus.req1_a : bus.req0_a;
  assign w_b    = w_id ? bus.req1_b : bus.req0_b;

  csa_tree_40x80 u_tree (
    .i_a     (w_a),
    .i_b     (w_b),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_id    <= 1'b0;
      r_s1_sum   <= '0;
      r_s1_carry <= '0;
      r_s2_valid <= 1'b0;
      r_s2_id    <= 1'b0;
      r_s2_p     <= '0;
      r_done     <= '0;
      r_last     <= 1'b1;
    end else begin
      if (r_s2_valid && bus.resp_ready) begin
        r_done <= r_done + 16'd1;
      end
      if (w_take) begin
        r_last <= w_id;
      end
      if (!w_stall) begin
        r_s1_valid <= w_take;
        if (w_take) begin
          r_s1_id    <= w_id;
          r_s1_sum   <= w_sum;
          r_s1_carry <= w_carry;
        end
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_id <= r_s1_id;
          r_s2_p  <= r_s1_sum + r_s1_carry;
        end
      end
    end
  end

  assign bus.resp_valid = r_s2_valid;
  assign bus.resp_id    = r_s2_id;
  assign bus.resp_p     = r_s2_p;
  assign bus.done_cnt   = r_done;

endmodule

// File: tb/tb_mul40_tree_sched.sv
// Bench for mul40_tree_sched: inputs change 2 time units after each rising
// edge, a negedge scoreboard checks every response against a reference product.
module tb_mul40_tree_sched;

  logic clk;
  logic rst_n;

  mul40_tree_sched_if #(.OPW(40), .PW(80)) bus ();

  mul40_tree_sched #(.OPW(40), .PW(80)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp;
  int          n_bad;
  int          n_fire;
  logic [80:0] exp_q[$];
  logic        prev_stall;
  logic [80:0] held;

  function automatic logic [79:0] ref_mul(input logic [39:0] a, input logic [39:0] b);
    logic [79:0] x;
    logic [79:0] y;
    x = {40'd0, a};
    y = {40'd0, b};
    return x * y;
  endfunction

  function automatic logic [39:0] rnd40();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[39:0];
  endfunction

  // Scoreboard / protocol monitor.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      n_cmp++;
      if (bus.req0_ready && bus.req1_ready) begin
        n_bad++;
        $display("FAIL ready_onehot: got r0=%0b r1=%0b, need at most one", bus.req0_ready, bus.req1_ready);
      end
      if (prev_stall) begin
        n_cmp++;
        if ({bus.resp_valid, bus.resp_id, bus.resp_p} !== {1'b1, held}) begin
          n_bad++;
          $display("FAIL stall_hold: got v=%0b id=%0b p=%h, need v=1 id=%0b p=%h",
                   bus.resp_valid, bus.resp_id, bus.resp_p, held[80], held[79:0]);
        end
      end
      if (bus.req0_valid && bus.req0_ready) exp_q.push_back({1'b0, ref_mul(bus.req0_a, bus.req0_b)});
      if (bus.req1_valid && bus.req1_ready) exp_q.push_back({1'b1, ref_mul(bus.req1_a, bus.req1_b)});
      if (bus.resp_valid && bus.resp_ready) begin
        n_cmp++;
        n_fire++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL resp_unexpected: got id=%0b p=%h, need no response", bus.resp_id, bus.resp_p);
        end else begin
          logic [80:0] e;
          e = exp_q.pop_front();
          if ({bus.resp_id, bus.resp_p} !== e) begin
            n_bad++;
            $display("FAIL resp_data: got id=%0b p=%h, need id=%0b p=%h",
                     bus.resp_id, bus.resp_p, e[80], e[79:0]);
          end
        end
      end
      prev_stall = bus.resp_valid & ~bus.resp_ready;
      held = {bus.resp_id, bus.resp_p};
    end
  end

  task automatic idle_inputs();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_a = '0;
    bus.req0_b = '0;
    bus.req1_a = '0;
    bus.req1_b = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    bus.resp_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    exp_q.delete();
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.resp_ready = 1'b1;
    rst_n = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_ready: got %b, need 00", {bus.req0_ready, bus.req1_ready});
    end
    n_cmp++;
    if ({bus.resp_valid, bus.resp_id, bus.resp_p, bus.done_cnt} !== {1'b0, 1'b0, 80'd0, 16'd0}) begin
      n_bad++;
      $display("FAIL reset_out: got v=%0b id=%0b p=%h cnt=%h, need all zero",
               bus.resp_valid, bus.resp_id, bus.resp_p, bus.done_cnt);
    end
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    bus.req0_a = 40'd3;
    bus.req0_b = 40'd5;
    bus.req0_valid = 1'b1;
    #1;
    n_cmp++;
    if (bus.req0_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_accept: got ready0=%0b, need 1", bus.req0_ready);
    end
    @(posedge clk);
    #2 bus.req0_valid = 1'b0;
    n_cmp++;
    if (bus.resp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_early: got resp_valid=%0b one cycle after accept, need 0", bus.resp_valid);
    end
    @(posedge clk);
    #2;
    n_cmp++;
    if ({bus.resp_valid, bus.resp_id, bus.resp_p} !== {1'b1, 1'b0, 80'd15}) begin
      n_bad++;
      $display("FAIL basic_resp: got v=%0b id=%0b p=%0d, need v=1 id=0 p=15",
               bus.resp_valid, bus.resp_id, bus.resp_p);
    end
    @(posedge clk);
    #2;
    n_cmp++;
    if (bus.done_cnt !== 16'd1) begin
      n_bad++;
      $display("FAIL basic_done: got %0d, need 1", bus.done_cnt);
    end
  endtask

  task automatic test_round_robin();
    int base;
    int g;
    do_reset();
    base = n_fire;
    for (int c = 0; c < 6; c++) begin
      bus.req0_a = rnd40();
      bus.req0_b = rnd40();
      bus.req1_a = rnd40();
      bus.req1_b = rnd40();
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      #1;
      g = bus.req0_ready ? 0 : (bus.req1_ready ? 1 : -1);
      n_cmp++;
      if (g != (c % 2)) begin
        n_bad++;
        $display("FAIL rr_grant%0d: got %0d, need %0d", c, g, c % 2);
      end
      @(posedge clk);
      #2;
    end
    idle_inputs();
    repeat (4) @(posedge clk);
    #2;
    n_cmp++;
    if (n_fire - base != 6) begin
      n_bad++;
      $display("FAIL rr_count: got %0d responses, need 6", n_fire - base);
    end
  endtask

  task automatic test_corners();
    logic [39:0] ta[3];
    logic [39:0] tb_[3];
    logic [79:0] tp[3];
    bit found;
    ta[0] = 40'hFF_FFFF_FFFF; tb_[0] = 40'hFF_FFFF_FFFF; tp[0] = 80'hFFFFFFFFFE0000000001;
    ta[1] = 40'd0;            tb_[1] = rnd40();          tp[1] = 80'd0;
    ta[2] = rnd40();          tb_[2] = 40'd0;            tp[2] = 80'd0;
    bus.resp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin
        bus.req1_a = ta[k]; bus.req1_b = tb_[k]; bus.req1_valid = 1'b1;
      end else begin
        bus.req0_a = ta[k]; bus.req0_b = tb_[k]; bus.req0_valid = 1'b1;
      end
      @(posedge clk);
      #2 idle_inputs();
      found = 1'b0;
      for (int w = 0; w < 8 && !found; w++) begin
        if (bus.resp_valid) found = 1'b1;
        else begin
          @(posedge clk);
          #2;
        end
      end
      n_cmp++;
      if (!found || bus.resp_p !== tp[k] || bus.resp_id !== (k == 1)) begin
        n_bad++;
        $display("FAIL corner%0d: got found=%0b id=%0b p=%h, need id=%0b p=%h",
                 k, found, bus.resp_id, bus.resp_p, (k == 1), tp[k]);
      end
      @(posedge clk);
      #2;
    end
  endtask

  task automatic test_backpressure();
    logic [39:0] oa[3];
    logic [39:0] ob[3];
    int issued;
    int base;
    for (int k = 0; k < 3; k++) begin
      oa[k] = rnd40();
      ob[k] = rnd40();
    end
    issued = 0;
    base = n_fire;
    bus.resp_ready = 1'b0;
    for (int c = 0; c < 25; c++) begin
      if (c == 5) begin
        n_cmp++;
        if (issued > 2 || bus.resp_valid !== 1'b1) begin
          n_bad++;
          $display("FAIL bp_stalled: got issued=%0d v=%0b, need issued<=2 v=1", issued, bus.resp_valid);
        end
        bus.resp_ready = 1'b1;
      end
      bus.req0_valid = (issued < 3);
      if (issued < 3) begin
        bus.req0_a = oa[issued];
        bus.req0_b = ob[issued];
      end
      #1;
      if (bus.req0_valid && bus.req0_ready) issued++;
      @(posedge clk);
      #2;
      if (issued == 3) bus.req0_valid = 1'b0;
    end
    n_cmp++;
    if (n_fire - base != 3 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL bp_drain: got %0d delivered, %0d pending, need 3 and 0",
               n_fire - base, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int base;
    bit seen;
    bus.resp_ready = 1'b0;
    bus.req1_a = rnd40();
    bus.req1_b = rnd40();
    bus.req1_valid = 1'b1;
    repeat (2) @(posedge clk);
    #2 idle_inputs();
    n_cmp++;
    if (bus.resp_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_fill: got resp_valid=%0b, need 1", bus.resp_valid);
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.resp_valid, bus.done_cnt, bus.resp_p} !== {1'b0, 16'd0, 80'd0}) begin
      n_bad++;
      $display("FAIL mid_async: got v=%0b cnt=%0d p=%h, need 0 0 0",
               bus.resp_valid, bus.done_cnt, bus.resp_p);
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    bus.resp_ready = 1'b1;
    base = n_fire;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #2 if (bus.resp_valid) seen = 1'b1;
    end
    n_cmp++;
    if (seen || n_fire != base || bus.done_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL mid_stale: got seen=%0b fires=%0d cnt=%0d, need 0 0 0",
               seen, n_fire - base, bus.done_cnt);
    end
  endtask

  task automatic test_wrap();
    int base;
    do_reset();
    base = n_fire;
    bus.req0_valid = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      bus.req0_a = rnd40();
      bus.req0_b = rnd40();
      @(posedge clk);
      #2;
    end
    idle_inputs();
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (bus.done_cnt !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL wrap_ffff: got %h, need ffff", bus.done_cnt);
    end
    bus.req0_a = rnd40();
    bus.req0_b = rnd40();
    bus.req0_valid = 1'b1;
    @(posedge clk);
    #2 idle_inputs();
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (bus.done_cnt !== 16'h0000 || n_fire - base != 65536) begin
      n_bad++;
      $display("FAIL wrap_zero: got cnt=%h fires=%0d, need 0000 65536", bus.done_cnt, n_fire - base);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, need finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    n_fire = 0;
    prev_stall = 1'b0;
    held = '0;
    rst_n = 1'b0;
    idle_inputs();
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #2;
    test_reset();
    test_basic();
    test_round_robin();
    test_corners();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mul40_tree_sched.md
MUL40_TREE_SCHED -- requirements
Module: mul40_tree_sched

Interface
REQ-001 SHALL have parameter OPW, default 40, operand width.
REQ-002 SHALL have parameter PW, default 80, product width (2*OPW).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports req0_valid/req1_valid  input  1  requester 0/1 operand pair present.
REQ-006 SHALL have ports req0_ready/req1_ready  output  1  requester 0/1 operand pair accepted this cycle.
REQ-007 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  OPW  unsigned operands.
REQ-008 SHALL have port resp_valid  output  1  result present.
REQ-009 SHALL have port resp_ready  input  1  consumer accepts result.
REQ-010 SHALL have port resp_id  output  1  index of the requester that owns the result.
REQ-011 SHALL have port resp_p  output  PW  product a*b.
REQ-012 SHALL have port done_cnt  output  16  count of completed response handshakes, wrapping.

Function
REQ-013 SHALL share one 40-line x 80-bit carry-save reduction tree between both requesters.
REQ-014 SHALL form partial-product line i as (b[i] ? a : 0) << i, zero-extended to PW, for i = 0..39.
REQ-015 SHALL use a 2-stage pipeline. S1 registers the tree sum/carry pair plus id. S2 registers sum+carry (mod 2^PW) as resp_p plus id.
REQ-016 SHALL, with no backpressure, assert resp_valid exactly 2 cycles after the accepting edge. Throughput is 1 op/cycle.
REQ-017 SHALL define stall = resp_valid & ~resp_ready. While stalled, S2 and S1 hold their contents and no new request is accepted.
REQ-018 SHALL let S1 advance into an empty S2 while S2 is not stalled. Bubbles collapse and no data is lost.
REQ-019 SHALL grant a request only when S1 is free or advancing this cycle.
REQ-020 SHALL assert at most one of req0_ready/req1_ready per cycle.
REQ-021 SHALL use round-robin arbitration. With a single valid requester, that requester is granted. With both valid, the requester not granted most recently is granted. The last-grant flag updates only on an accepted handshake.
REQ-022 SHALL keep readys combinational from the valids and the stall state. They SHALL NOT depend combinationally on req*_a/b.
REQ-023 SHALL keep resp_p/resp_id stable while resp_valid & ~resp_ready.
REQ-024 SHALL increment done_cnt on each resp_valid & resp_ready, wrapping 0xFFFF -> 0x0000.
REQ-025 SHALL compute the result so that 0*x = 0 and (2^40-1)^2 = 0xFFFFFFFFFE0000000001 exactly.

Reset
REQ-026 SHALL, on rst_n low, asynchronously clear resp_valid, S1 valid, resp_p, resp_id, done_cnt and the last-grant flag. The last-grant flag resets to 1, so requester 0 wins the first tie.
REQ-027 SHALL discard in-flight operations when reset is asserted mid-operation. No response is produced for them after release.
REQ-028 SHALL hold req0_ready = req1_ready = 0 while rst_n is low.
REQ-029 SHALL accept requests from the first rising edge after rst_n deasserts.

Structure
REQ-030 SHALL place OPW, PW and the partial-product line count (40) in the shared package mul40_pkg.
REQ-031 SHALL instantiate the existing reduction tree csa_tree_40x80 (sub-module, combinational) once. All sequencing, arbitration and the final adder SHALL be in mul40_tree_sched.

Verification
REQ-032 SHALL cover: req0 a=3, b=5, resp_ready=1 -> resp_valid 2 cycles later, resp_p=15, resp_id=0, done_cnt=1.
REQ-033 SHALL cover: both valid every cycle for 6 cycles after reset -> grants alternate 0,1,0,1,0,1; responses in the same order.
REQ-034 SHALL cover: a=b=0xFFFFFFFFFF -> resp_p=0xFFFFFFFFFE0000000001.
REQ-035 SHALL cover: resp_ready=0 for 5 cycles with 3 ops issued -> at most 2 accepted, resp_p held stable; on release all 3 delivered in order, none lost.
REQ-036 SHALL cover: rst_n pulsed low with S1 and S2 full -> resp_valid=0 immediately, no stale response after release, done_cnt=0.
REQ-037 SHALL cover: done_cnt preloaded via 65536 handshakes -> wraps to 0.
